// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset controller.
//   pll_state_t : controller state encoding
//   RETRY_W     : width of the retry counter
//   RETRY_MAX   : saturation value of the retry counter
//   retry_inc() : saturating increment of the retry counter
package pll_rst_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_t;

    localparam int unsigned RETRY_W = 4;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(15);

    // Saturating increment: holds at RETRY_MAX instead of wrapping.
    function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] r);
        return (r == RETRY_MAX) ? r : r + RETRY_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk : destination clock
//   rst : asynchronous active-high reset, both flops clear to 0
//   d   : asynchronous input
//   q   : synchronized output
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the downstream core reset. Lock loss while running restarts the
// sequence and bumps a saturating retry counter.
//   refclk     : 50 MHz reference clock
//   rst        : asynchronous active-high reset
//   pll_locked : PLL lock indicator (asynchronous to refclk)
//   pll_rst    : reset drive to the PLL, high only while pulsing
//   core_reset : active-high reset to downstream logic, low only in RUN
//   ready      : high only in RUN
//   retry_cnt  : saturating count of lock timeouts plus lock losses
// Build option: define PLL_LOCK_TIMEOUT_EN to enable the WAIT_LOCK timeout and
// retry; otherwise WAIT_LOCK waits indefinitely and only RUN lock losses count.
module pll_reset_ctrl
    import pll_rst_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 500000,
    parameter int unsigned STABLE_CYCLES = 1024
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               core_reset,
    output logic               ready,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    pll_state_t         state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [RETRY_W-1:0] retry_nx;
    logic               locked_s;

    sync_2ff u_sync_locked (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Next-state, shared counter and retry counter.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        retry_nx = retry_cnt;
        case (state)
            PLL_RST: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                // Lock is checked first so it wins over a coincident timeout.
                if (locked_s) begin
                    state_nx = STABLE;
                    cnt_nx   = '0;
                end
`ifdef PLL_LOCK_TIMEOUT_EN
                else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_nx = PLL_RST;
                    cnt_nx   = '0;
                    retry_nx = retry_inc(retry_cnt);
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
`endif
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_nx = PLL_RST;
                    cnt_nx   = '0;
                    retry_nx = retry_inc(retry_cnt);
                end
            end
            default: begin
                state_nx = PLL_RST;
                cnt_nx   = '0;
            end
        endcase
    end

    // State register; outputs are decoded from next-state so they change
    // on the same edge as the state and never glitch.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state      <= PLL_RST;
            cnt        <= '0;
            retry_cnt  <= '0;
            pll_rst    <= 1'b1;
            core_reset <= 1'b1;
            ready      <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            retry_cnt  <= retry_nx;
            pll_rst    <= (state_nx == PLL_RST);
            core_reset <= (state_nx != RUN);
            ready      <= (state_nx == RUN);
        end
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Testbench for pll_reset_ctrl: a cycle model pushes expected outputs into a
// queue on every refclk rising edge; a monitor pops and compares on the
// falling edge. Directed checks cover pulse width, latencies and async reset.
module tb_pll_reset_ctrl;

    localparam int RST_C = 4;
    localparam int LT_C  = 20;
    localparam int ST_C  = 8;

    typedef struct packed {
        logic       pll_rst;
        logic       core_reset;
        logic       ready;
        logic [3:0] retry;
    } obs_t;

    localparam obs_t RESET_OBS = '{pll_rst: 1'b1, core_reset: 1'b1, ready: 1'b0, retry: 4'd0};

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       core_reset;
    logic       ready;
    logic [3:0] retry_cnt;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    pll_reset_ctrl #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (LT_C),
        .STABLE_CYCLES (ST_C)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .core_reset (core_reset),
        .ready      (ready),
        .retry_cnt  (retry_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Reference model: attempt-level bookkeeping. A reset pulse lasts RST_C
    // edges; afterwards RUN needs ST_C+1 consecutive synchronized-high edges
    // (first one leaves WAIT_LOCK); LT_C consecutive low edges in WAIT_LOCK
    // (not counting the edge that dropped out of STABLE) time out.
    bit m_pulse;
    int m_pulse_n;
    bit m_run;
    int m_hi;
    int m_lo;
    int m_retry;
    bit p1, p2, m_ls;

    function void model_reset();
        m_pulse = 1'b1; m_pulse_n = 0; m_run = 1'b0;
        m_hi = 0; m_lo = 0; m_retry = 0; p1 = 1'b0; p2 = 1'b0;
    endfunction

    function void model_retry();
        m_retry   = (m_retry < 15) ? m_retry + 1 : 15;
        m_pulse   = 1'b1;
        m_pulse_n = 0;
        m_run     = 1'b0;
        m_hi      = 0;
        m_lo      = 0;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge refclk);
            if (rst) begin
                model_reset();
                exp_q.push_back(RESET_OBS);
            end else begin
                m_ls = p2;
                p2   = p1;
                p1   = pll_locked;
                if (m_pulse) begin
                    m_pulse_n++;
                    if (m_pulse_n == RST_C) begin
                        m_pulse = 1'b0; m_hi = 0; m_lo = 0;
                    end
                end else if (m_run) begin
                    if (!m_ls) model_retry();
                end else if (m_ls) begin
                    m_hi++;
                    m_lo = 0;
                    if (m_hi == ST_C + 1) m_run = 1'b1;
                end else if (m_hi > 0) begin
                    m_hi = 0;
                    m_lo = 0;
                end else begin
                    m_lo++;
`ifdef PLL_LOCK_TIMEOUT_EN
                    if (m_lo == LT_C) model_retry();
`endif
                end
                exp_q.push_back('{pll_rst: m_pulse, core_reset: !m_run, ready: m_run,
                                  retry: 4'(m_retry)});
            end
        end
    end

    // Monitor: one expected entry per cycle; async reset overrides.
    obs_t mon_e, mon_a;
    initial begin
        forever begin
            @(negedge refclk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t: no expected entry", $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (rst) mon_e = RESET_OBS;
                mon_a = '{pll_rst: pll_rst, core_reset: core_reset, ready: ready, retry: retry_cnt};
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got pll_rst=%b core_reset=%b ready=%b retry=%0d, expected pll_rst=%b core_reset=%b ready=%b retry=%0d",
                             $time, mon_a.pll_rst, mon_a.core_reset, mon_a.ready, mon_a.retry,
                             mon_e.pll_rst, mon_e.core_reset, mon_e.ready, mon_e.retry);
                end
            end
        end
    end

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #2;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            tick(1);
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_int({tag, "_pll_rst"}, int'(pll_rst), 1);
        check_int({tag, "_core_reset"}, int'(core_reset), 1);
        check_int({tag, "_ready"}, int'(ready), 0);
        check_int({tag, "_retry"}, int'(retry_cnt), 0);
    endtask

    initial begin
        int n;
        int highs;
        int rises;
        bit prev;

        rst = 1'b1;
        pll_locked = 1'b0;
        tick(3);
        check_reset_outputs("reset");

        // Normal bring-up: lock arrives 10 cycles after release.
        rst = 1'b0;
        highs = int'(pll_rst);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            highs += int'(pll_rst);
        end
        check_int("bringup_pll_rst_width", highs, RST_C);
        pll_locked = 1'b1;
        wait_ready(n);
        check_int("bringup_ready_latency", n, 2 + 1 + ST_C);
        check_int("bringup_core_reset", int'(core_reset), 0);
        check_int("bringup_retry", int'(retry_cnt), 0);

        // Lock loss while running.
        pll_locked = 1'b0;
        n = 0;
        while (!core_reset && n < 10) begin
            tick(1);
            n++;
        end
        check_int("loss_core_reset_within_4", (core_reset && n <= 4) ? 1 : 0, 1);
        highs = int'(pll_rst);
        for (int i = 0; i < RST_C + 1; i++) begin
            tick(1);
            highs += int'(pll_rst);
        end
        check_int("loss_pll_rst_width", highs, RST_C);
        check_int("loss_retry", int'(retry_cnt), 1);

        // Glitch during STABLE: 5 high, 1 low, then high.
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        check_int("glitch_not_ready", int'(ready), 0);
        wait_ready(n);
        check_int("glitch_ready_latency", n, 2 + 1 + ST_C);
        check_int("glitch_retry", int'(retry_cnt), 1);

        // Async reset in STABLE after a second loss.
        pll_locked = 1'b0;
        tick(3 + RST_C + 1);
        pll_locked = 1'b1;
        tick(5);
        check_int("midrst_pre_ready", int'(ready), 0);
        check_int("midrst_pre_retry", int'(retry_cnt), 2);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick(2);
        rst = 1'b0;
        wait_ready(n);
        check_int("midrst_ready_latency", n, RST_C + 1 + ST_C);

        // Long loss of lock: timeouts and saturation, or a single pulse.
        pll_locked = 1'b0;
        prev = pll_rst;
        rises = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (pll_rst && !prev) rises++;
            prev = pll_rst;
        end
`ifdef PLL_LOCK_TIMEOUT_EN
        check_int("timeout_repulses", (rises >= 40) ? 1 : 0, 1);
        check_int("timeout_retry_saturated", int'(retry_cnt), 15);
`else
        check_int("no_timeout_single_pulse", rises, 1);
        check_int("no_timeout_retry", int'(retry_cnt), 1);
`endif

        // Randomized lock activity checked by the model.
        for (int s = 0; s < 40; s++) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            tick(int'($urandom_range(1, 30)));
        end
        pll_locked = 1'b1;
        tick(40);
        @(negedge refclk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
